pad_th_seq: RTL



---
 rtl/pad_pkg.sv | 30 +++
 rtl/pad_th_seq.sv | 95 +++++++++
 2 files changed

// File: rtl/pad_pkg.sv
// Shared definitions for the six-button pad TH-cycle sequencer:
// phase encodings, timeout defaults and the phase-advance helper.
package pad_pkg;

   localparam int TIMEOUT_DEFAULT = 12000;
   localparam int TW_DEFAULT      = 14;

   typedef enum logic [2:0] {
      PH_IDLE = 3'd0,
      PH_N1   = 3'd1,
      PH_N2   = 3'd2,
      PH_XID  = 3'd3,
      PH_ONES = 3'd4
   } ph_t;

   // Phase after a TH falling edge; the last phase folds back to 1, never to idle.
   function automatic ph_t ph_next(input ph_t cur);
      ph_t nxt;
      case (cur)
         PH_IDLE: nxt = PH_N1;
         PH_N1:   nxt = PH_N2;
         PH_N2:   nxt = PH_XID;
         PH_XID:  nxt = PH_ONES;
         PH_ONES: nxt = PH_N1;
         default: nxt = PH_IDLE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/pad_th_seq.sv
// Six-button pad TH-cycle sequencer: tracks TH edges on CE ticks, runs the
// phase counter with inactivity timeout and registers the read-mux selects.
module pad_th_seq
   import pad_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int TW      = TW_DEFAULT
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       CE,
   input  logic       J3BUT,
   input  logic       TH,
   output logic [2:0] CNT,
   output logic       SEL_ID,
   output logic       SEL_XYZ,
   output logic       SEL_ONES,
   output logic       TMO_EV
);

   localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT - 1);

   ph_t           cnt_q,      cnt_d;
   logic [TW-1:0] tmr_q,      tmr_d;
   logic          th_q,       th_d;
   logic          sel_id_q,   sel_id_d;
   logic          sel_xyz_q,  sel_xyz_d;
   logic          sel_ones_q, sel_ones_d;
   logic          tmo_ev_q,   tmo_ev_d;
   logic          fall;
   logic          rise;

   always_comb begin
      fall       = th_q & ~TH;
      rise       = ~th_q & TH;
      th_d       = th_q;
      cnt_d      = cnt_q;
      tmr_d      = tmr_q;
      sel_id_d   = sel_id_q;
      sel_xyz_d  = sel_xyz_q;
      sel_ones_d = sel_ones_q;
      // The event flag is a single-CLK pulse, so it drops even on non-CE cycles.
      tmo_ev_d   = 1'b0;

      if (CE) begin
         th_d = TH;
         if (J3BUT) begin
            cnt_d = PH_IDLE;
            tmr_d = '0;
         end else if (fall) begin
            cnt_d = ph_next(cnt_q);
            tmr_d = '0;
         end else if (rise) begin
            tmr_d = '0;
         end else if (tmr_q < TMR_MAX) begin
            tmr_d = tmr_q + TW'(1);
         end else begin
            // Expired: timer stays saturated at its last count.
            cnt_d    = PH_IDLE;
            tmo_ev_d = (cnt_q != PH_IDLE);
         end

         sel_id_d   = ~J3BUT & (cnt_d == PH_XID)  & ~TH;
         sel_xyz_d  = ~J3BUT & (cnt_d == PH_XID)  &  TH;
         sel_ones_d = ~J3BUT & (cnt_d == PH_ONES) & ~TH;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q      <= PH_IDLE;
         tmr_q      <= '0;
         th_q       <= 1'b1;
         sel_id_q   <= 1'b0;
         sel_xyz_q  <= 1'b0;
         sel_ones_q <= 1'b0;
         tmo_ev_q   <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         tmr_q      <= tmr_d;
         th_q       <= th_d;
         sel_id_q   <= sel_id_d;
         sel_xyz_q  <= sel_xyz_d;
         sel_ones_q <= sel_ones_d;
         tmo_ev_q   <= tmo_ev_d;
      end
   end

   assign CNT      = cnt_q;
   assign SEL_ID   = sel_id_q;
   assign SEL_XYZ  = sel_xyz_q;
   assign SEL_ONES = sel_ones_q;
   assign TMO_EV   = tmo_ev_q;

endmodule
